// File: rtl/hs_memory_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hs_memory_if
//  Purpose  : Valid/ready request and response channels of hs_memory.
//  Ports    : none; signals are reached through the modports
//             master - request producer / response consumer
//             slave  - memory side (hs_memory)
//  Signals  : req_valid, req_ready, req_we, req_addr, req_wdata, req_be,
//             rsp_valid, rsp_ready, rsp_rdata
//  Revision : 1.0 - initial release
// ============================================================================
interface hs_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();
  localparam int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/hs_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hs_memory
//  Purpose  : Single-port RAM with valid/ready request and response channels,
//             per-byte write enables, 1- or 2-cycle read latency and a
//             credit-limited first-word-fall-through response FIFO. A
//             hardware sweep fills every word with INIT_VALUE after reset or
//             on clear.
//  Ports    : clk    - clock
//             reset  - synchronous active-high reset
//             clear  - pulse: restart the init sweep
//             busy   - init sweep in progress
//             bus    - hs_memory_if.slave request/response channels
//  Revision : 1.0 - initial release
// ============================================================================
module hs_memory #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '1,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RSP_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  output logic        busy,
  hs_memory_if.slave  bus
);

  localparam int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1);

  localparam logic [0:0]            c_ST_INIT   = 1'b0;
  localparam logic [0:0]            c_ST_RUN    = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
  localparam logic [PTR_W-1:0]      c_PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0]      c_CREDITS   = CNT_W'(RSP_DEPTH);

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_sweep_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_fifo_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];

  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_nonempty;
  logic [DATA_WIDTH-1:0] w_push_data;

  // --------------------------------------------------------------------------
  // Handshake. req_ready depends only on registers so a requester can
  // present valid combinationally from ready without forming a loop.
  // --------------------------------------------------------------------------
  assign busy          = (r_state == c_ST_INIT);
  assign bus.req_ready = (r_state == c_ST_RUN) && (r_outstanding < c_CREDITS);

  assign w_accept   = bus.req_valid && bus.req_ready && !reset;
  assign w_wr_acc   = w_accept && bus.req_we;
  assign w_rd_acc   = w_accept && !bus.req_we;

  assign w_nonempty    = (r_fifo_count != '0);
  assign bus.rsp_valid = w_nonempty;
  // Head entry is held until popped, so data is stable under backpressure.
  assign bus.rsp_rdata = w_nonempty ? r_fifo[r_rd_ptr] : '0;
  assign w_pop         = w_nonempty && bus.rsp_ready;

  // --------------------------------------------------------------------------
  // Init / run state machine and sweep address
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state      <= c_ST_INIT;
      r_sweep_addr <= '0;
    end else if (r_state == c_ST_INIT) begin
      if (r_sweep_addr == c_LAST_ADDR) begin
        r_state <= c_ST_RUN;
      end
      r_sweep_addr <= r_sweep_addr + ADDR_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Storage array. Sweep and request writes never coincide because
  // req_ready is low throughout INIT.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == c_ST_INIT) begin
        // A clear restarts the sweep; the word at the current address is
        // rewritten later in the new pass.
        if (!clear) begin
          r_mem[r_sweep_addr] <= INIT_VALUE;
        end
      end else if (w_wr_acc) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (bus.req_be[i]) begin
            r_mem[bus.req_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
              bus.req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline: the array is sampled at the accept edge. Latency 1 pushes
  // straight into the FIFO on that edge; latency 2 holds the word for one
  // extra stage.
  // --------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign w_push      = w_rd_acc;
      assign w_push_data = r_mem[bus.req_addr];
    end else begin : g_lat2
      logic                  r_s1_valid;
      logic [DATA_WIDTH-1:0] r_s1_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= '0;
        end else begin
          r_s1_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_s1_data <= r_mem[bus.req_addr];
          end
        end
      end

      assign w_push      = r_s1_valid;
      assign w_push_data = r_s1_data;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Response FIFO. Pushes never find it full: every push was preceded by a
  // read accept that consumed one of RSP_DEPTH credits.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifo[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_fifo_count <= r_fifo_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_fifo_count <= r_fifo_count - CNT_W'(1);
      end
    end
  end

  // Credits cover both the read pipeline and the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else if (w_rd_acc && !w_pop) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (w_pop && !w_rd_acc) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hs_memory
//  Purpose  : Self-checking bench for hs_memory. Two instances share one
//             stimulus source: dut_a (latency 1, depth 2) and dut_b
//             (latency 2, depth 3); sel chooses which one is driven/observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_memory;
  localparam int DW  = 16;
  localparam int BW  = 8;
  localparam int AW  = 4;
  localparam int BEW = DW / BW;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           clear     = 1'b0;
  logic           sel       = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_we    = 1'b0;
  logic [AW-1:0]  req_addr  = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic [BEW-1:0] req_be    = '0;
  logic           rsp_ready = 1'b0;
  logic           rand_ready = 1'b0;

  logic busy_a, busy_b, clear_a, clear_b;
  logic obs_busy, obs_req_ready, obs_rsp_valid;
  logic [DW-1:0] obs_rsp_rdata;

  always #5 clk = ~clk;

  hs_memory_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_a ();
  hs_memory_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_b ();

  assign if_a.req_valid = req_valid & ~sel;
  assign if_b.req_valid = req_valid & sel;
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;
  assign if_a.req_be    = req_be;
  assign if_b.req_be    = req_be;
  assign if_a.rsp_ready = sel ? 1'b1 : rsp_ready;
  assign if_b.rsp_ready = sel ? rsp_ready : 1'b1;
  assign clear_a        = clear & ~sel;
  assign clear_b        = clear & sel;

  assign obs_busy      = sel ? busy_b : busy_a;
  assign obs_req_ready = sel ? if_b.req_ready : if_a.req_ready;
  assign obs_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign obs_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;

  hs_memory #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
              .INIT_VALUE(16'hFFFF), .READ_LATENCY(1), .RSP_DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .clear(clear_a), .busy(busy_a), .bus(if_a));

  hs_memory #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
              .INIT_VALUE(16'hFFFF), .READ_LATENCY(2), .RSP_DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b), .busy(busy_b), .bus(if_b));

  // Reference model: word array plus queue of expected read data in order.
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_pop = '0;
  int checks = 0, failures = 0, cyc = 0, pop_count = 0;
  int first_acc_cyc = -1, first_vld_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'hFFFF;
  endtask

  // One clock: sample the handshake mid-cycle, check any popped word,
  // then advance the model by what the edge did.
  task automatic tick(output logic acc);
    logic s_rst, s_acc, s_pop, s_clr, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [BEW-1:0] s_be;
    @(negedge clk);
    s_rst = reset;  s_clr = clear;
    s_acc = req_valid & obs_req_ready;
    s_pop = obs_rsp_valid & rsp_ready;
    s_we = req_we;  s_addr = req_addr;  s_wdata = req_wdata;  s_be = req_be;
    s_rdata = obs_rsp_rdata;
    if (!s_rst && s_pop) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("rsp_data", 32'(s_rdata), 32'(exp_q[0]));
      last_pop = s_rdata;
      pop_count++;
    end
    if (!s_rst && s_acc && first_acc_cyc < 0) first_acc_cyc = cyc;
    if (!s_rst && obs_rsp_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      exp_q.delete();
      model_fill();
    end else begin
      if (s_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_acc) begin
        if (s_we) begin
          for (int i = 0; i < BEW; i++)
            if (s_be[i]) model_mem[s_addr][i*BW +: BW] = s_wdata[i*BW +: BW];
        end else begin
          exp_q.push_back(model_mem[s_addr]);
        end
      end
      if (s_clr) model_fill();
    end
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    acc = s_acc && !s_rst;
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) tick(a);
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [BEW-1:0] be);
    logic a;
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    a = 1'b0; n = 0;
    while (!a && n < 200) begin
      tick(a);
      n++;
    end
    req_valid = 1'b0;
    if (!a) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    idle(3);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_no_extra_valid"}, 32'(obs_rsp_valid), 32'd0);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    logic rdy_seen;
    n = 0; rdy_seen = 1'b0;
    while (obs_busy && n < 100) begin
      if (obs_req_ready) rdy_seen = 1'b1;
      idle(1);
      n++;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
    chk({tag, "_ready_low_in_init"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic burst_test(input logic which, input int lat, input string tag);
    logic a;
    int n, gaps, ai, pc0;
    sel = which;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), DW'(i * 3), 2'b11);
    idle(2);
    first_acc_cyc = -1; first_vld_cyc = -1;
    gaps = 0; ai = 0; n = 0; pc0 = pop_count;
    req_valid = 1'b1; req_we = 1'b0;
    while (ai < 16 && n < 100) begin
      req_addr = AW'(ai);
      tick(a);
      n++;
      if (a) ai++; else gaps++;
    end
    req_valid = 1'b0;
    drain(tag);
    chk({tag, "_gaps"}, 32'(gaps), 32'd0);
    chk({tag, "_latency"}, 32'(first_vld_cyc - first_acc_cyc), 32'(lat));
    chk({tag, "_pops"}, 32'(pop_count - pc0), 32'd16);
    chk({tag, "_last_data"}, 32'(last_pop), 32'd45);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int acc_cnt, n, pc0;
    logic [DW-1:0] held;
    model_fill();

    // Reset state
    reset = 1'b1;
    idle(3);
    chk("rst_busy", 32'(obs_busy), 32'd1);
    chk("rst_req_ready", 32'(obs_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(obs_rsp_rdata), 32'd0);
    reset = 1'b0;
    wait_busy("init");

    // Every word holds INIT_VALUE after the sweep
    rsp_ready = 1'b1;
    pc0 = pop_count;
    for (int i = 0; i < 16; i++) do_req(1'b0, AW'(i), '0, '0);
    drain("t1");
    chk("t1_pops", 32'(pop_count - pc0), 32'd16);
    chk("t1_last_data", 32'(last_pop), 32'hFFFF);

    // Byte-lane writes
    do_req(1'b1, 4'd3, 16'h1234, 2'b11);
    do_req(1'b1, 4'd3, 16'hABCD, 2'b01);
    do_req(1'b0, 4'd3, '0, '0);
    drain("t2a");
    chk("t2_lane_merge", 32'(last_pop), 32'h12CD);
    do_req(1'b1, 4'd3, 16'h5555, 2'b00);
    do_req(1'b0, 4'd3, '0, '0);
    drain("t2b");
    chk("t2_be_zero_noop", 32'(last_pop), 32'h12CD);

    // Back-to-back reads, latency 1
    burst_test(1'b0, 1, "t3_lat1");

    // Backpressure: credits stop acceptance, head data held
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = AW'(1 + acc_cnt);
      tick(a);
      if (a) acc_cnt++;
    end
    chk("t4_accepts_at_credit_limit", 32'(acc_cnt), 32'd2);
    chk("t4_ready_low", 32'(obs_req_ready), 32'd0);
    chk("t4_valid_held", 32'(obs_rsp_valid), 32'd1);
    held = obs_rsp_rdata;
    idle(3);
    chk("t4_rdata_stable", 32'(obs_rsp_rdata), 32'(held));
    chk("t4_head_data", 32'(held), 32'd3);
    pc0 = pop_count;
    rsp_ready = 1'b1;
    n = 0;
    while (acc_cnt < 5 && n < 100) begin
      req_addr = AW'(1 + acc_cnt);
      tick(a);
      if (a) acc_cnt++;
      n++;
    end
    req_valid = 1'b0;
    drain("t4");
    chk("t4_pops", 32'(pop_count - pc0), 32'd5);
    chk("t4_last_data", 32'(last_pop), 32'd15);

    // clear with reads in flight
    do_req(1'b1, 4'd5, 16'h0042, 2'b11);
    rsp_ready = 1'b0;
    pc0 = pop_count;
    do_req(1'b0, 4'd5, '0, '0);
    do_req(1'b0, 4'd5, '0, '0);
    clear = 1'b1;
    rsp_ready = 1'b1;
    idle(1);
    clear = 1'b0;
    wait_busy("t5_clear");
    chk("t5_inflight_pops", 32'(pop_count - pc0), 32'd2);
    chk("t5_inflight_data", 32'(last_pop), 32'h0042);
    do_req(1'b0, 4'd5, '0, '0);
    drain("t5");
    chk("t5_swept_data", 32'(last_pop), 32'hFFFF);

    // Reset with reads outstanding
    do_req(1'b1, 4'd8, 16'h0777, 2'b11);
    rsp_ready = 1'b0;
    do_req(1'b0, 4'd7, '0, '0);
    do_req(1'b0, 4'd8, '0, '0);
    reset = 1'b1;
    idle(1);
    chk("t6_rsp_valid_after_reset", 32'(obs_rsp_valid), 32'd0);
    chk("t6_busy_after_reset", 32'(obs_busy), 32'd1);
    reset = 1'b0;
    wait_busy("t6");
    rsp_ready = 1'b1;
    pc0 = pop_count;
    for (int i = 0; i < 16; i++) do_req(1'b0, AW'(i), '0, '0);
    drain("t6");
    chk("t6_pops", 32'(pop_count - pc0), 32'd16);
    chk("t6_word8_swept", 32'(last_pop), 32'hFFFF);

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
             DW'($urandom), BEW'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    drain("rand");

    // Back-to-back reads, latency 2
    burst_test(1'b1, 2, "t3_lat2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
